// File: rtl/matrix_addsub_unit.sv
// matrix_addsub_unit
// Row-streaming element-wise add/subtract engine for the matrix coprocessor.
// One packed row of A and B is accepted per input handshake, and one packed
// result row comes out per output handshake. A start/done pair frames each
// ROWS-row operation. Each lane is computed at EW+1 bits so that overflow can
// be detected. The lane result either wraps or saturates. Per-lane overflow is
// reported with each row, and a sticky flag collects overflow across the whole
// operation.
module matrix_addsub_unit #(
   parameter int LANES = 5,
   parameter int EW    = 8,
   parameter int ROWS  = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            op,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES*EW-1:0]   a_row,
   input  logic [LANES*EW-1:0]   b_row,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES*EW-1:0]   out_row,
   output logic [LANES-1:0]      out_ovf,
   output logic                  ovf,
   output logic                  busy,
   output logic                  done
);

   // Counters must be able to hold ROWS itself, because in_cnt==ROWS closes the input side.
   localparam int CW = $clog2(ROWS + 1);
   localparam logic [CW-1:0] ROWS_C = CW'(ROWS);
   localparam logic [CW-1:0] LAST_C = CW'(ROWS - 1);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   // Saturation rails for an EW-bit two's complement element.
   localparam logic [EW-1:0] SAT_MAX = {1'b0, {(EW-1){1'b1}}};
   localparam logic [EW-1:0] SAT_MIN = {1'b1, {(EW-1){1'b0}}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t                state_r;
   logic [1:0]            op_r;
   logic [CW-1:0]         in_cnt_r;
   logic [CW-1:0]         out_cnt_r;
   logic                  out_valid_r;
   logic [LANES*EW-1:0]   out_row_r;
   logic [LANES-1:0]      out_ovf_r;
   logic                  ovf_r;
   logic                  busy_r;
   logic                  done_r;

   logic                  in_ready_s;
   logic                  in_fire_s;
   logic                  out_fire_s;
   logic [LANES*EW-1:0]   res_row_s;
   logic [LANES-1:0]      res_ovf_s;
   logic [EW:0]           lane_s;

   // One lane. Both operands are sign-extended to EW+1 bits, so the sum or
   // difference cannot lose information. Overflow means the top two bits of
   // the wide result disagree. The return value is {overflow, result}.
   function automatic logic [EW:0] lane_calc(
      input logic [EW-1:0] a,
      input logic [EW-1:0] b,
      input logic          sub,
      input logic          sat
   );
      logic [EW:0]   ax;
      logic [EW:0]   bx;
      logic [EW:0]   s;
      logic          of;
      logic [EW-1:0] r;
      ax = {a[EW-1], a};
      bx = {b[EW-1], b};
      if (sub) begin
         s = ax - bx;
      end else begin
         s = ax + bx;
      end
      of = s[EW] ^ s[EW-1];
      if (sat && of) begin
         // The true sign is in s[EW], so clamp toward that rail.
         if (s[EW]) begin
            r = SAT_MIN;
         end else begin
            r = SAT_MAX;
         end
      end else begin
         r = s[EW-1:0];
      end
      return {of, r};
   endfunction

   // Evaluate every lane of the incoming row with the operation latched at start.
   always_comb begin
      res_row_s = '0;
      res_ovf_s = '0;
      lane_s    = '0;
      for (int j = 0; j < LANES; j++) begin
         lane_s = lane_calc(a_row[j*EW +: EW], b_row[j*EW +: EW], op_r[0], op_r[1]);
         res_row_s[j*EW +: EW] = lane_s[EW-1:0];
         res_ovf_s[j]          = lane_s[EW];
      end
   end

   // Accept a row only while running, with rows left to take, and with the output register free or draining.
   always_comb begin
      if (state_r == ST_RUN) begin
         in_ready_s = (in_cnt_r < ROWS_C) && (!out_valid_r || out_ready);
      end else begin
         in_ready_s = 1'b0;
      end
   end

   // Handshake qualifiers for the current cycle.
   always_comb begin
      in_fire_s  = in_valid && in_ready_s;
      out_fire_s = out_valid_r && out_ready;
   end

   // Control FSM and datapath registers. rst wins over every other input and aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         op_r        <= 2'b00;
         in_cnt_r    <= '0;
         out_cnt_r   <= '0;
         out_valid_r <= 1'b0;
         out_row_r   <= '0;
         out_ovf_r   <= '0;
         ovf_r       <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r   <= ST_RUN;
                  op_r      <= op;
                  in_cnt_r  <= '0;
                  out_cnt_r <= '0;
                  ovf_r     <= 1'b0;
                  busy_r    <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               done_r <= 1'b0;
               // A new row replaces the one leaving, so out_valid stays high when both sides fire.
               if (in_fire_s) begin
                  out_row_r   <= res_row_s;
                  out_ovf_r   <= res_ovf_s;
                  out_valid_r <= 1'b1;
                  in_cnt_r    <= in_cnt_r + ONE_C;
                  ovf_r       <= ovf_r | (|res_ovf_s);
               end else if (out_fire_s) begin
                  out_valid_r <= 1'b0;
               end else begin
                  out_valid_r <= out_valid_r;
               end
               if (out_fire_s) begin
                  out_cnt_r <= out_cnt_r + ONE_C;
                  if (out_cnt_r == LAST_C) begin
                     state_r <= ST_DONE;
                     busy_r  <= 1'b0;
                     done_r  <= 1'b1;
                  end else begin
                     state_r <= ST_RUN;
                  end
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               // The done pulse lasts exactly one cycle. ovf keeps its value for software to read.
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
               done_r      <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_row   = out_row_r;
   assign out_ovf   = out_ovf_r;
   assign ovf       = ovf_r;
   assign busy      = busy_r;
   assign done      = done_r;

endmodule

// File: doc/matrix_addsub_unit.md
# matrix_addsub_unit

Parametrised, sequential row-streaming add/subtract engine for the matrix coprocessor. It accepts one packed row of each operand matrix per handshake and produces one packed result row. It supports add and subtract, wrap and saturate modes, and per-lane plus sticky whole-matrix overflow reporting. It sits between the operand row fetch and the result writeback. Rows move through valid/ready handshakes, and a start/done pair frames each matrix operation.

## Interface
Parameters:
- LANES, 5, elements per row
- EW, 8, element width in bits (two's complement)
- ROWS, 5, rows per matrix operation

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a matrix operation; sampled only in IDLE
- op  in  2  op[0]: 0=add, 1=sub (a−b); op[1]: 0=wrap, 1=saturate; latched on accepted start
- in_valid  in  1  a_row/b_row valid
- in_ready  out  1  unit accepts a row this cycle
- a_row  in  LANES*EW  operand A row; element 0 in MSBs
- b_row  in  LANES*EW  operand B row; same packing
- out_valid  out  1  out_row valid
- out_ready  in  1  consumer accepts out_row
- out_row  out  LANES*EW  result row; same packing
- out_ovf  out  LANES  per-lane overflow of out_row; bit LANES-1 = element 0
- ovf  out  1  sticky OR of all lane overflows in current/last operation
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when operation completes

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=0.
  - start=1 → RUN. Latch op, clear in_cnt, out_cnt and ovf.
- RUN:
  - in_ready = (in_cnt<ROWS) && (!out_valid || out_ready).
  - Input fire (in_valid && in_ready): compute all lanes, register out_row/out_ovf, set out_valid, in_cnt++.
  - Output fire (out_valid && out_ready) with no same-cycle input fire: clear out_valid. out_cnt++ on every output fire.
  - Output fire on row ROWS-1 → DONE.
- DONE:
  - done=1, busy=0 → IDLE next cycle.
  - ovf holds until the next accepted start.
- start outside IDLE is ignored; op changes outside IDLE are ignored.
- Per lane i, arithmetic is done at EW+1 bits:
  - s = sext(a_i) ± sext(b_i).
  - Lane overflow: s[EW] != s[EW-1].
  - Wrap mode: result = s[EW-1:0].
  - Saturate mode with overflow: s[EW]=0 → 2^(EW-1)−1; s[EW]=1 → −2^(EW-1). Otherwise s[EW-1:0].
- out_ovf reports overflow in both modes. ovf |= |lane_ovf on each input fire.
- Lanes are fully independent; there is no carry between lanes.

## Timing
- Reset values: in_ready=0, out_valid=0, out_row=0, out_ovf=0, ovf=0, busy=0, done=0, state=IDLE, counters=0.
- rst has priority over every other input. rst asserted mid-operation aborts it; in-flight rows are discarded and no done pulse is issued.
- Start accepted at edge N → busy=1 and in_ready may be 1 from N+1.
- Latency: input fire at edge k → out_valid=1, out_row valid after edge k (visible cycle k+1).
- Throughput: one row per cycle while out_ready=1. Simultaneous output fire and input fire in the same cycle keeps out_valid=1 with the new row.
- Backpressure: out_valid=1 && out_ready=0 → out_row/out_ovf held stable, in_ready=0.
- in_cnt==ROWS → in_ready=0 even if the output register is free.
- The last row's output fire at edge m → done=1 during cycle m+1. busy=0 from m+1. start is accepted again from cycle m+2.

## Test plan
(LANES=5, EW=8, ROWS=5)
- Reset: assert rst 2 cycles while driving start=1 and in_valid=1 → every output 0 and state IDLE; after release with start=0, no activity.
- Add/wrap, a={7F,01,80,FF,10}, b={01,01,FF,01,20} → out_row={80,02,7F,00,30}, out_ovf=5'b10100, ovf=1 sticky through done. Remaining 4 rows of zeros → out_row=0, out_ovf=0.
- Add/saturate, same operands → out_row={7F,02,80,00,30}, out_ovf=5'b10100.
- Sub/wrap then sub/saturate, a={80,05,7F,00,01}, b={01,07,FF,80,01}:
  - wrap → {7F,FE,80,80,00}, out_ovf=5'b10110.
  - saturate → {80,FE,7F,7F,00}.
- Backpressure: out_ready=0 for 3 cycles after the first out_valid → in_ready=0 and out_row stable. Release → exactly 5 output fires, one done pulse, and back-to-back rows at 1/cycle once out_ready=1.
- Reset mid-op after 2 output fires → IDLE, no done pulse. A new start with clean operands runs all 5 rows, ovf=0, and done pulses exactly once.
